// File: rtl/hazard_detection_unit.sv
// Hazard controller for the 5-stage core: tracks in-flight destinations for the
// forwarding unit and resolves load-use stalls, memory-wait freezes and branch flushes.
module hazard_detection_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [4:0]       id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             ex_branch_taken,
  input  logic             mem_ready,
  output logic [4:0]       id_ex_rs,
  output logic [4:0]       id_ex_rt,
  output logic [4:0]       ex_mem_rd,
  output logic [4:0]       mem_wb_rd,
  output logic             ex_mem_regwrite,
  output logic             mem_wb_regwrite,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             flush_if_id,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    ACT_ADVANCE,
    ACT_MEM_STALL,
    ACT_FLUSH,
    ACT_LOAD_USE
  } action_e;

  logic             id_ex_valid_q, id_ex_valid_d;
  logic [4:0]       id_ex_rs_q, id_ex_rs_d;
  logic [4:0]       id_ex_rt_q, id_ex_rt_d;
  logic [4:0]       id_ex_rd_q, id_ex_rd_d;
  logic             id_ex_regwrite_q, id_ex_regwrite_d;
  logic             id_ex_memread_q, id_ex_memread_d;

  logic             ex_mem_valid_q, ex_mem_valid_d;
  logic [4:0]       ex_mem_rd_q, ex_mem_rd_d;
  logic             ex_mem_regwrite_q, ex_mem_regwrite_d;
  logic             ex_mem_memread_q, ex_mem_memread_d;

  logic             mem_wb_valid_q, mem_wb_valid_d;
  logic [4:0]       mem_wb_rd_q, mem_wb_rd_d;
  logic             mem_wb_regwrite_q, mem_wb_regwrite_d;

  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic             mem_stall;
  logic             rs_hit;
  logic             rt_hit;
  logic             load_use;
  action_e          action;

  // Hazard detection; r0 destinations never stall since r0 is hard-wired zero.
  always_comb begin
    mem_stall = ex_mem_valid_q & ex_mem_memread_q & ~mem_ready;
    rs_hit    = id_uses_rs & (id_rs == id_ex_rd_q);
    rt_hit    = id_uses_rt & (id_rt == id_ex_rd_q);
    load_use  = id_valid & id_ex_valid_q & id_ex_memread_q &
                (id_ex_rd_q != 5'd0) & (rs_hit | rt_hit);

    action = ACT_ADVANCE;
    if (!rst_n)               action = ACT_ADVANCE;
    else if (mem_stall)       action = ACT_MEM_STALL;
    else if (ex_branch_taken) action = ACT_FLUSH;
    else if (load_use)        action = ACT_LOAD_USE;
  end

  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    flush_if_id = 1'b0;
    stall       = 1'b0;

    id_ex_valid_d     = id_ex_valid_q;
    id_ex_rs_d        = id_ex_rs_q;
    id_ex_rt_d        = id_ex_rt_q;
    id_ex_rd_d        = id_ex_rd_q;
    id_ex_regwrite_d  = id_ex_regwrite_q;
    id_ex_memread_d   = id_ex_memread_q;
    ex_mem_valid_d    = ex_mem_valid_q;
    ex_mem_rd_d       = ex_mem_rd_q;
    ex_mem_regwrite_d = ex_mem_regwrite_q;
    ex_mem_memread_d  = ex_mem_memread_q;
    mem_wb_valid_d    = mem_wb_valid_q;
    mem_wb_rd_d       = mem_wb_rd_q;
    mem_wb_regwrite_d = mem_wb_regwrite_q;

    if (action != ACT_MEM_STALL) begin
      mem_wb_valid_d    = ex_mem_valid_q;
      mem_wb_rd_d       = ex_mem_rd_q;
      mem_wb_regwrite_d = ex_mem_regwrite_q;
      ex_mem_valid_d    = id_ex_valid_q;
      ex_mem_rd_d       = id_ex_rd_q;
      ex_mem_regwrite_d = id_ex_regwrite_q;
      ex_mem_memread_d  = id_ex_memread_q;
      id_ex_valid_d     = 1'b0;
      id_ex_rs_d        = 5'd0;
      id_ex_rt_d        = 5'd0;
      id_ex_rd_d        = 5'd0;
      id_ex_regwrite_d  = 1'b0;
      id_ex_memread_d   = 1'b0;
    end

    case (action)
      ACT_MEM_STALL: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        stall       = 1'b1;
      end
      ACT_FLUSH: begin
        flush_if_id = 1'b1;
      end
      ACT_LOAD_USE: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        stall       = 1'b1;
      end
      default: begin
        if (id_valid) begin
          id_ex_valid_d    = 1'b1;
          id_ex_rs_d       = id_rs;
          id_ex_rt_d       = id_rt;
          id_ex_rd_d       = id_rd;
          id_ex_regwrite_d = id_regwrite;
          id_ex_memread_d  = id_memread;
        end
      end
    endcase

    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != {CNT_W{1'b1}}))
      stall_count_d = stall_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_ex_valid_q     <= 1'b0;
      id_ex_rs_q        <= 5'd0;
      id_ex_rt_q        <= 5'd0;
      id_ex_rd_q        <= 5'd0;
      id_ex_regwrite_q  <= 1'b0;
      id_ex_memread_q   <= 1'b0;
      ex_mem_valid_q    <= 1'b0;
      ex_mem_rd_q       <= 5'd0;
      ex_mem_regwrite_q <= 1'b0;
      ex_mem_memread_q  <= 1'b0;
      mem_wb_valid_q    <= 1'b0;
      mem_wb_rd_q       <= 5'd0;
      mem_wb_regwrite_q <= 1'b0;
      stall_count_q     <= '0;
    end else begin
      id_ex_valid_q     <= id_ex_valid_d;
      id_ex_rs_q        <= id_ex_rs_d;
      id_ex_rt_q        <= id_ex_rt_d;
      id_ex_rd_q        <= id_ex_rd_d;
      id_ex_regwrite_q  <= id_ex_regwrite_d;
      id_ex_memread_q   <= id_ex_memread_d;
      ex_mem_valid_q    <= ex_mem_valid_d;
      ex_mem_rd_q       <= ex_mem_rd_d;
      ex_mem_regwrite_q <= ex_mem_regwrite_d;
      ex_mem_memread_q  <= ex_mem_memread_d;
      mem_wb_valid_q    <= mem_wb_valid_d;
      mem_wb_rd_q       <= mem_wb_rd_d;
      mem_wb_regwrite_q <= mem_wb_regwrite_d;
      stall_count_q     <= stall_count_d;
    end
  end

  // Bubbles are masked so the forwarding unit never matches a squashed stage.
  always_comb begin
    id_ex_rs        = id_ex_valid_q  ? id_ex_rs_q  : 5'd0;
    id_ex_rt        = id_ex_valid_q  ? id_ex_rt_q  : 5'd0;
    ex_mem_rd       = ex_mem_valid_q ? ex_mem_rd_q : 5'd0;
    mem_wb_rd       = mem_wb_valid_q ? mem_wb_rd_q : 5'd0;
    ex_mem_regwrite = ex_mem_valid_q & ex_mem_regwrite_q;
    mem_wb_regwrite = mem_wb_valid_q & mem_wb_regwrite_q;
    stall_count     = stall_count_q;
  end

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Self-checking bench for hazard_detection_unit: a stage-array reference model
// feeds a scoreboard, plus directed checks against hand-derived constants.
module tb_hazard_detection_unit;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             id_valid;
  logic [4:0]       id_rs, id_rt, id_rd;
  logic             id_uses_rs, id_uses_rt;
  logic             id_regwrite, id_memread;
  logic             ex_branch_taken;
  logic             mem_ready;
  logic [4:0]       id_ex_rs, id_ex_rt, ex_mem_rd, mem_wb_rd;
  logic             ex_mem_regwrite, mem_wb_regwrite;
  logic             pc_write, if_id_write, flush_if_id, stall;
  logic [CNT_W-1:0] stall_count;

  always #5 clk = ~clk;

  hazard_detection_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .ex_branch_taken(ex_branch_taken), .mem_ready(mem_ready),
    .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .ex_mem_rd(ex_mem_rd), .mem_wb_rd(mem_wb_rd),
    .ex_mem_regwrite(ex_mem_regwrite), .mem_wb_regwrite(mem_wb_regwrite),
    .pc_write(pc_write), .if_id_write(if_id_write), .flush_if_id(flush_if_id),
    .stall(stall), .stall_count(stall_count)
  );

  typedef struct {
    logic       v;
    logic [4:0] rs, rt, rd;
    logic       rw, mr;
  } stage_t;

  typedef struct {
    logic       regKnown;
    logic       pcWrite, ifIdWrite, flush, stall;
    logic [4:0] idExRs, idExRt, exMemRd, memWbRd;
    logic       exMemRw, memWbRw;
    int         cnt;
  } expect_t;

  expect_t scoreboard[$];
  stage_t  pipe[3];
  int      modelCnt   = 0;
  logic    modelKnown = 1'b0;
  int      checksDone   = 0;
  int      checksPassed = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checksDone++;
    if (actual === expected) checksPassed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  function automatic stage_t bubble();
    stage_t b;
    b.v = 1'b0; b.rs = 5'd0; b.rt = 5'd0; b.rd = 5'd0; b.rw = 1'b0; b.mr = 1'b0;
    return b;
  endfunction

  // Drives one cycle, pushes the model's expectation, then pops and compares it.
  task automatic applyStimulus(input logic rstN, input logic ready, input logic br,
                               input logic valid, input logic [4:0] rd, input logic rw,
                               input logic mr, input logic [4:0] rs, input logic usesRs,
                               input logic [4:0] rt, input logic usesRt);
    expect_t e;
    stage_t  nxt;
    logic    memWait, luse;
    @(negedge clk);
    rst_n = rstN; mem_ready = ready; ex_branch_taken = br; id_valid = valid;
    id_rd = rd; id_regwrite = rw; id_memread = mr;
    id_rs = rs; id_uses_rs = usesRs; id_rt = rt; id_uses_rt = usesRt;

    memWait = pipe[1].v && pipe[1].mr && !ready;
    luse = 1'b0;
    if (valid && pipe[0].v && pipe[0].mr && pipe[0].rd != 5'd0) begin
      if (usesRs && rs == pipe[0].rd) luse = 1'b1;
      if (usesRt && rt == pipe[0].rd) luse = 1'b1;
    end
    e.regKnown = modelKnown;
    if (!rstN)        {e.pcWrite, e.ifIdWrite, e.flush, e.stall} = 4'b1100;
    else if (memWait) {e.pcWrite, e.ifIdWrite, e.flush, e.stall} = 4'b0001;
    else if (br)      {e.pcWrite, e.ifIdWrite, e.flush, e.stall} = 4'b1110;
    else if (luse)    {e.pcWrite, e.ifIdWrite, e.flush, e.stall} = 4'b0001;
    else              {e.pcWrite, e.ifIdWrite, e.flush, e.stall} = 4'b1100;
    e.idExRs  = pipe[0].rs;
    e.idExRt  = pipe[0].rt;
    e.exMemRd = pipe[1].rd;
    e.memWbRd = pipe[2].rd;
    e.exMemRw = pipe[1].rw;
    e.memWbRw = pipe[2].rw;
    e.cnt     = modelCnt;
    scoreboard.push_back(e);

    #2;
    e = scoreboard.pop_front();
    checkOutput("pc_write",    32'(pc_write),    32'(e.pcWrite));
    checkOutput("if_id_write", 32'(if_id_write), 32'(e.ifIdWrite));
    checkOutput("flush_if_id", 32'(flush_if_id), 32'(e.flush));
    checkOutput("stall",       32'(stall),       32'(e.stall));
    if (e.regKnown) begin
      checkOutput("id_ex_rs",        32'(id_ex_rs),        32'(e.idExRs));
      checkOutput("id_ex_rt",        32'(id_ex_rt),        32'(e.idExRt));
      checkOutput("ex_mem_rd",       32'(ex_mem_rd),       32'(e.exMemRd));
      checkOutput("mem_wb_rd",       32'(mem_wb_rd),       32'(e.memWbRd));
      checkOutput("ex_mem_regwrite", 32'(ex_mem_regwrite), 32'(e.exMemRw));
      checkOutput("mem_wb_regwrite", 32'(mem_wb_regwrite), 32'(e.memWbRw));
      checkOutput("stall_count",     32'(stall_count),     32'(e.cnt));
    end

    if (!rstN) begin
      for (int i = 0; i < 3; i++) pipe[i] = bubble();
      modelCnt   = 0;
      modelKnown = 1'b1;
    end else begin
      if (!memWait) begin
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        if (br || luse || !valid) pipe[0] = bubble();
        else begin
          nxt.v = 1'b1; nxt.rs = rs; nxt.rt = rt; nxt.rd = rd; nxt.rw = rw; nxt.mr = mr;
          pipe[0] = nxt;
        end
      end
      if (e.stall && modelCnt < CNT_MAX) modelCnt++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1, 1, 0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0);
  endtask

  task automatic issueLoad(input logic [4:0] rd);
    applyStimulus(1, 1, 0, 1, rd, 1, 1, 5'd0, 0, 5'd0, 0);
  endtask

  task automatic memWaitCycle();
    applyStimulus(1, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) pipe[i] = bubble();
    rst_n = 1'b0; mem_ready = 1'b1; ex_branch_taken = 1'b0; id_valid = 1'b0;
    id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_regwrite = 1'b0; id_memread = 1'b0;

    $display("[TB] reset");
    repeat (2) applyStimulus(0, 1, 0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0);
    idle(1);
    checkOutput("rst_stall",       32'(stall),           32'd0);
    checkOutput("rst_pc_write",    32'(pc_write),        32'd1);
    checkOutput("rst_ex_mem_rd",   32'(ex_mem_rd),       32'd0);
    checkOutput("rst_mem_wb_rw",   32'(mem_wb_regwrite), 32'd0);
    checkOutput("rst_stall_count", 32'(stall_count),     32'd0);

    $display("[TB] load-use");
    issueLoad(5'd5);
    applyStimulus(1, 1, 0, 1, 5'd6, 1, 0, 5'd5, 1, 5'd0, 0);
    checkOutput("lu_stall",       32'(stall),       32'd1);
    checkOutput("lu_pc_write",    32'(pc_write),    32'd0);
    checkOutput("lu_if_id_write", 32'(if_id_write), 32'd0);
    applyStimulus(1, 1, 0, 1, 5'd6, 1, 0, 5'd5, 1, 5'd0, 0);
    checkOutput("lu_bubble_rs",   32'(id_ex_rs),  32'd0);
    checkOutput("lu_ex_mem_rd",   32'(ex_mem_rd), 32'd5);
    checkOutput("lu_replay_stall", 32'(stall),    32'd0);
    idle(1);
    checkOutput("lu_id_ex_rs",    32'(id_ex_rs),    32'd5);
    checkOutput("lu_mem_wb_rd",   32'(mem_wb_rd),   32'd5);
    checkOutput("lu_stall_count", 32'(stall_count), 32'd1);
    idle(3);

    $display("[TB] r0 and unused operand");
    issueLoad(5'd0);
    applyStimulus(1, 1, 0, 1, 5'd8, 1, 0, 5'd0, 1, 5'd0, 0);
    checkOutput("r0_stall", 32'(stall), 32'd0);
    issueLoad(5'd7);
    applyStimulus(1, 1, 0, 1, 5'd8, 1, 0, 5'd1, 1, 5'd7, 0);
    checkOutput("unused_rt_stall", 32'(stall), 32'd0);
    idle(3);

    $display("[TB] memory wait");
    issueLoad(5'd9);
    idle(1);
    repeat (3) begin
      memWaitCycle();
      checkOutput("mw_stall",     32'(stall),     32'd1);
      checkOutput("mw_pc_write",  32'(pc_write),  32'd0);
      checkOutput("mw_ex_mem_rd", 32'(ex_mem_rd), 32'd9);
    end
    idle(1);
    checkOutput("mw_release_stall", 32'(stall), 32'd0);
    idle(1);
    checkOutput("mw_mem_wb_rd",   32'(mem_wb_rd),   32'd9);
    checkOutput("mw_stall_count", 32'(stall_count), 32'd4);
    idle(2);

    $display("[TB] branch over load-use");
    issueLoad(5'd3);
    applyStimulus(1, 1, 1, 1, 5'd10, 1, 0, 5'd3, 1, 5'd0, 0);
    checkOutput("br_flush",    32'(flush_if_id), 32'd1);
    checkOutput("br_stall",    32'(stall),       32'd0);
    checkOutput("br_pc_write", 32'(pc_write),    32'd1);
    idle(1);
    checkOutput("br_id_ex_rs",    32'(id_ex_rs),    32'd0);
    checkOutput("br_ex_mem_rd",   32'(ex_mem_rd),   32'd3);
    checkOutput("br_stall_count", 32'(stall_count), 32'd4);
    idle(3);

    $display("[TB] saturation");
    issueLoad(5'd4);
    idle(1);
    repeat (20) memWaitCycle();
    idle(2);
    checkOutput("sat_stall_count", 32'(stall_count), 32'(CNT_MAX));

    $display("[TB] reset during stall");
    issueLoad(5'd11);
    idle(1);
    memWaitCycle();
    applyStimulus(0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0);
    checkOutput("rs_mid_stall",    32'(stall),    32'd0);
    checkOutput("rs_mid_pc_write", 32'(pc_write), 32'd1);
    idle(1);
    checkOutput("rs_after_ex_mem_rd", 32'(ex_mem_rd),   32'd0);
    checkOutput("rs_after_count",     32'(stall_count), 32'd0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1,
                    logic'($urandom_range(0, 3) != 0),
                    logic'($urandom_range(0, 7) == 0),
                    logic'($urandom_range(0, 4) != 0),
                    5'($urandom_range(0, 7)),
                    logic'($urandom_range(0, 1)),
                    logic'($urandom_range(0, 2) == 0),
                    5'($urandom_range(0, 7)),
                    logic'($urandom_range(0, 1)),
                    5'($urandom_range(0, 7)),
                    logic'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", checksPassed, checksDone);
    $finish;
  end

endmodule
